// File: rtl/xgmii_retransmit_64b32b_fifo.sv
// XGMII 64-bit to 32-bit width converter with an elastic FIFO.
// 64-bit columns are buffered, then emitted as two 32-bit columns:
// lanes 0-3 first, lanes 4-7 second. Idle columns are inserted only
// on 64-bit word boundaries when the FIFO runs dry.

package xgmii_retransmit_64b32b_fifo_pkg;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        ena;
    } xgmii64_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ctrl;
        logic        ena;
    } xgmii32_t;
endpackage

module xgmii_retransmit_64b32b_fifo
    import xgmii_retransmit_64b32b_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter bit IDLE_FILL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  xgmii64_t                 rx,
    output xgmii32_t                 tx,
    output logic                     ovf,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [31:0]    IDLE_D   = 32'h07070707;
    localparam logic [3:0]     IDLE_C   = 4'hF;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    // Storage and bookkeeping
    logic [71:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic [15:0]   r_drop_cnt;

    // Output path
    state_t        r_state;
    state_t        w_state_nxt;
    logic [35:0]   r_hold;       // {ctrl[7:4], data[63:32]} of the word being split
    logic [35:0]   w_hold_nxt;
    xgmii32_t      r_tx;
    xgmii32_t      w_tx_nxt;

    logic [71:0]   w_head;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_empty = (r_level == {(AW+1){1'b0}});
    assign w_full  = (r_level == LVL_FULL);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write
    assign w_wr   = rx.ena && (!w_full || w_pop);
    assign w_drop = rx.ena && w_full && !w_pop;

    // Next-state and next-output logic of the half-word sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_hold_nxt    = r_hold;
        w_tx_nxt.data = IDLE_D;
        w_tx_nxt.ctrl = IDLE_C;
        w_tx_nxt.ena  = IDLE_FILL;
        case (r_state)
            ST_LOW: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_tx_nxt.data = w_head[31:0];
                    w_tx_nxt.ctrl = w_head[67:64];
                    w_tx_nxt.ena  = 1'b1;
                    w_hold_nxt    = {w_head[71:68], w_head[63:32]};
                    w_state_nxt   = ST_HIGH;
                end else begin
                    w_state_nxt   = ST_LOW;
                end
            end
            ST_HIGH: begin
                w_tx_nxt.data = r_hold[31:0];
                w_tx_nxt.ctrl = r_hold[35:32];
                w_tx_nxt.ena  = 1'b1;
                w_state_nxt   = ST_LOW;
            end
            default: begin
                w_state_nxt   = ST_LOW;
            end
        endcase
    end

    // Sequencer state, holding register and registered output column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOW;
            r_hold      <= 36'h0;
            r_tx.data   <= IDLE_D;
            r_tx.ctrl   <= IDLE_C;
            r_tx.ena    <= IDLE_FILL;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_tx        <= w_tx_nxt;
        end
    end

    // FIFO data array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {rx.ctrl, rx.data};
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'h0001;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign tx       = r_tx;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;
    assign level    = r_level;

endmodule

// File: tb/tb_xgmii_retransmit_64b32b_fifo.sv
// Self-checking bench for xgmii_retransmit_64b32b_fifo.
// Each driven word that the FIFO accepts pushes its two expected 32-bit
// halves into a scoreboard; a cycle model pops them when the converter
// is due to emit them and compares against tx.

module tb_xgmii_retransmit_64b32b_fifo;
    import xgmii_retransmit_64b32b_fifo_pkg::*;

    localparam int          DEPTH     = 16;
    localparam bit          IDLE_FILL = 1'b1;
    localparam logic [36:0] IDLE_COL  = {IDLE_FILL, 4'hF, 32'h07070707};

    logic        clk;
    logic        rst_n;
    xgmii64_t    rx;
    xgmii32_t    tx;
    logic        ovf;
    logic [15:0] drop_cnt;
    logic [$clog2(DEPTH):0] level;

    int checks   = 0;
    int failures = 0;

    // scoreboard of expected 32-bit columns {ena, ctrl, data}
    logic [36:0] sb[$];
    int          m_cnt;
    bit          m_high;
    int          m_drops;
    bit          m_ovf;
    int          max_lvl;

    xgmii_retransmit_64b32b_fifo #(
        .DEPTH     (DEPTH),
        .IDLE_FILL (IDLE_FILL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .tx       (tx),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .level    (level)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt   = 0;
        m_high  = 1'b0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle of stimulus (called at a negedge), advance the model
    // across the next posedge and compare at the following negedge.
    task automatic step(input logic ena, input logic [63:0] d, input logic [7:0] c);
        logic [36:0] e;
        int          cnt0;
        bit          popped;
        rx.ena  = ena;
        rx.data = d;
        rx.ctrl = c;
        cnt0    = m_cnt;
        popped  = 1'b0;
        if (m_high) begin
            e      = sb.pop_front();
            m_high = 1'b0;
        end else if (m_cnt > 0) begin
            e      = sb.pop_front();
            m_cnt  = m_cnt - 1;
            m_high = 1'b1;
            popped = 1'b1;
        end else begin
            e = IDLE_COL;
        end
        if (ena) begin
            if ((cnt0 < DEPTH) || popped) begin
                sb.push_back({1'b1, c[3:0], d[31:0]});
                sb.push_back({1'b1, c[7:4], d[63:32]});
                m_cnt = m_cnt + 1;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops = m_drops + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("tx_column", {27'd0, tx.ena, tx.ctrl, tx.data}, {27'd0, e});
        check_val("level", 64'(level), 64'(m_cnt));
        check_val("ovf", 64'(ovf), 64'(m_ovf));
        check_val("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        if (int'(level) > max_lvl) max_lvl = int'(level);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 64'h0, 8'h00);
    endtask

    // Assert reset at a negedge, check reset values immediately, hold 3 cycles
    task automatic do_reset();
        rst_n = 1'b0;
        rx    = '0;
        #1;
        model_reset();
        check_val("rst_tx", {27'd0, tx.ena, tx.ctrl, tx.data}, {27'd0, IDLE_COL});
        check_val("rst_level", 64'(level), 64'd0);
        check_val("rst_ovf", 64'(ovf), 64'd0);
        check_val("rst_drop", 64'(drop_cnt), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] w;
        logic [7:0]  c;
        rst_n   = 1'b0;
        rx      = '0;
        max_lvl = 0;
        model_reset();
        @(negedge clk);

        // reset then idle
        do_reset();
        idle_steps(4);

        // single word: low half after k+1, high half after k+2, then idle
        step(1'b1, 64'h0807060504030201, 8'h00);
        idle_steps(4);

        // frame at 50% duty: start, 10 data words, terminate in lane 4
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                w = 64'hD5555555555555FB;
                c = 8'h01;
            end else if (i == 11) begin
                w = 64'h070707FD44332211;
                c = 8'hF0;
            end else begin
                w = {32'(i) * 32'h01010101, 32'hA0B0C000 | 32'(i)};
                c = 8'h00;
            end
            step(1'b1, w, c);
            step(1'b0, 64'h0, 8'h00);
        end
        idle_steps(4);

        // start character in lane 4
        step(1'b1, 64'h555555FB07070707, 8'h1F);
        idle_steps(4);

        // overflow: 35 back-to-back words fill the FIFO and drop two
        max_lvl = 0;
        for (int i = 0; i < 35; i++) begin
            step(1'b1, {32'hC0DE0000 | 32'(i), 32'(i) * 32'h00010001}, 8'(i));
        end
        check_val("ovf_max_level", 64'(max_lvl), 64'd16);
        check_val("ovf_flag", 64'(ovf), 64'd1);
        check_val("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
        idle_steps(40);
        check_val("ovf_sticky", 64'(ovf), 64'd1);
        check_val("ovf_drained", 64'(level), 64'd0);

        // reset mid-frame: 10 back-to-back words leave level=5 in HIGH
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, {32'h12340000 | 32'(i), 32'h56780000 | 32'(i)}, 8'h00);
        end
        check_val("pre_rst_level", 64'(level), 64'd5);
        do_reset();
        step(1'b1, 64'hBBBBBBBBAAAAAAAA, 8'h00);
        idle_steps(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
